rv_hazard_ctrl: RTL and testbench
=================================

Name: rv_hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB).
- Tracks in-flight register writes in a scoreboard shift register with entries EX, MEM and WB.
- Produces stall, bubble and flush controls, registered forwarding selects aligned to EX, and a saturating stall-cycle counter.
- Adds to the existing combinational RAW check: load-use detection, branch flush, data-memory wait freeze, and a selectable forwarding/no-forwarding mode.

Parameters:
- REG_ADDR_W, 5, register index width (32 architectural registers).
- FWD_EN, 1, 1 = forwarding from EX/MEM and MEM/WB; 0 = stall until the producer reaches WB.
- CNT_W, 32, stall_cycles counter width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_ADDR_W  ID source 1 index.
- id_rs2  in  REG_ADDR_W  ID source 2 index.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  REG_ADDR_W  ID destination index.
- id_reg_write  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- dmem_busy  in  1  data memory not ready; the whole pipeline must hold.
- perf_clear  in  1  synchronous clear of stall_cycles.
- stall  out  1  hold PC and IF/ID this cycle.
- bubble  out  1  load NOP into ID/EX this cycle.
- flush  out  1  load NOP into IF/ID this cycle.
- freeze  out  1  all pipeline registers hold (equals dmem_busy).
- fwd_sel_rs1  out  2  EX operand A source: 0 = ID/EX register data, 1 = EX/MEM result, 2 = MEM/WB result.
- fwd_sel_rs2  out  2  same encoding for operand B.
- stall_cycles  out  CNT_W  saturating count of stall or freeze cycles.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Reset clears all scoreboard entries to invalid and sets fwd_sel_rs1/rs2 to 0 and stall_cycles to 0.
  - While reset is high, stall, bubble, flush and freeze are forced to 0.
- Scoreboard entry fields: {valid, rd, wr, load}. Entries: E0 = EX, E1 = MEM, E2 = WB.
  - wr is forced to 0 when rd == 0; x0 is never tracked.
- Match: matchK(rsX) = rsX_used && rsX != 0 && EK.valid && EK.wr && EK.rd == rsX.
- E2 is never a hazard. The register file is write-before-read, so a same-cycle WB write is visible to ID.
- Hazard rules (combinational on current inputs and entries):
  - FWD_EN=1: hazard = id_valid && (match0(rs1) || match0(rs2)) && E0.load. This is a one-cycle load-use stall.
  - FWD_EN=0: hazard = id_valid && any of match0 or match1 on rs1 or rs2.
- Combinational outputs:
  - freeze = dmem_busy.
  - flush = branch_taken && !dmem_busy.
  - bubble = !dmem_busy && (branch_taken || hazard).
  - stall = !dmem_busy && hazard && !branch_taken.
  - Flush wins over hazard. branch_taken is ignored while dmem_busy is high, and the producer holds it until accepted.
- Scoreboard advance when dmem_busy = 0:
  - E2 <= E1, E1 <= E0.
  - E0 <= {id fields} if id_valid && !hazard && !branch_taken; otherwise E0 <= invalid.
  - When dmem_busy = 1, all entries hold.
- Forwarding selects (registered, loaded on the same condition as E0):
  - Per source: 1 if match0, else 2 if match1, else 0. The youngest producer wins.
  - Forced to 0 when FWD_EN = 0, or when E0 is loaded invalid.
  - Held while dmem_busy = 1.
- stall_cycles:
  - perf_clear has priority and sets the counter to 0.
  - Otherwise it increments by 1 on each cycle with stall || freeze, saturating at all-ones.
- Latency:
  - Control outputs are combinational within the same cycle.
  - fwd_sel is valid in the cycle the instruction occupies EX.
- Reset mid-operation: all state is cleared immediately, with no pending stall or flush carried over.

Test Plan:
- ALU forwarding (FWD_EN=1): add x5 (E0), then ID reads rs1 = 5 -> stall = 0 and fwd_sel_rs1 = 1 next cycle. One instruction later (producer in E1) -> fwd_sel_rs1 = 2.
- Load-use: lw x7 in E0, ID reads rs2 = 7 -> stall = 1 and bubble = 1 for exactly one cycle. Next cycle stall = 0 and fwd_sel_rs2 = 2. stall_cycles = 1.
- FWD_EN=0: add x3, then ID reads rs1 = 3 -> stall for 2 cycles, then proceed with fwd_sel = 0. stall_cycles = 2.
- x0 and priority:
  - Writes to x0 followed by a read of x0 -> no stall, fwd_sel = 0.
  - x4 written by both E0 and E1 -> fwd_sel = 1.
- Branch vs hazard: branch_taken = 1 with a load-use hazard in the same cycle -> flush = 1, bubble = 1, stall = 0, and E0 invalid next cycle.
- Freeze and counter:
  - dmem_busy high for 3 cycles -> freeze = 1, entries and fwd_sel held, stall_cycles += 3.
  - Counter preset near all-ones saturates.
  - perf_clear -> 0.
  - Asserting reset mid-freeze -> all outputs 0 immediately.

Source files
------------

// File: rtl/rv_hazard_ctrl_if.sv
// Hazard-controller bundle: ID-stage operand info, pipeline events and the resulting pipeline controls.
interface rv_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) ();
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_is_load;
    logic                  branch_taken;
    logic                  dmem_busy;
    logic                  perf_clear;
    logic                  stall;
    logic                  bubble;
    logic                  flush;
    logic                  freeze;
    logic [1:0]            fwd_sel_rs1;
    logic [1:0]            fwd_sel_rs2;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_is_load, branch_taken, dmem_busy, perf_clear,
        input  stall, bubble, flush, freeze, fwd_sel_rs1, fwd_sel_rs2, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
               id_reg_write, id_is_load, branch_taken, dmem_busy, perf_clear,
        output stall, bubble, flush, freeze, fwd_sel_rs1, fwd_sel_rs2, stall_cycles
    );
endinterface

// File: rtl/rv_hazard_ctrl.sv
// 5-stage RV32I hazard controller: EX/MEM/WB write scoreboard, stall/bubble/flush/freeze,
// EX-aligned forwarding selects and a saturating stall-cycle counter.
module rv_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned CNT_W      = 32
) (
    input logic             clk,
    input logic             reset,
    rv_hazard_ctrl_if.slave hz
);
    localparam int unsigned SB_DEPTH  = 3;
    localparam logic [1:0]  SEL_REG   = 2'd0;
    localparam logic [1:0]  SEL_EXMEM = 2'd1;
    localparam logic [1:0]  SEL_MEMWB = 2'd2;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
        logic                  load;
    } sb_entry_t;

    sb_entry_t        sb_q [SB_DEPTH];
    sb_entry_t        e0_d;
    logic [1:0]       sel_rs1_q, sel_rs2_q;
    logic [1:0]       sel_rs1_d, sel_rs2_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             m0_rs1, m1_rs1, m0_rs2, m1_rs2;
    logic             hazard, stall_raw, load_e0;

    function automatic logic src_match(input sb_entry_t e,
                                       input logic [REG_ADDR_W-1:0] rs,
                                       input logic used);
        return used && (rs != '0) && e.valid && e.wr && (e.rd == rs);
    endfunction

    // WB (sb_q[2]) is never a hazard: the register file is write-before-read.
    always_comb begin
        m0_rs1 = src_match(sb_q[0], hz.id_rs1, hz.id_rs1_used);
        m1_rs1 = src_match(sb_q[1], hz.id_rs1, hz.id_rs1_used);
        m0_rs2 = src_match(sb_q[0], hz.id_rs2, hz.id_rs2_used);
        m1_rs2 = src_match(sb_q[1], hz.id_rs2, hz.id_rs2_used);
        hazard = 1'b0;
        if (FWD_EN)
            hazard = hz.id_valid && (m0_rs1 || m0_rs2) && sb_q[0].load;
        else
            hazard = hz.id_valid && (m0_rs1 || m1_rs1 || m0_rs2 || m1_rs2);
        stall_raw = hazard && !hz.branch_taken && !hz.dmem_busy;
        load_e0   = hz.id_valid && !hazard && !hz.branch_taken;
    end

    // Next EX entry and forwarding selects; youngest producer wins.
    always_comb begin
        e0_d      = '0;
        sel_rs1_d = SEL_REG;
        sel_rs2_d = SEL_REG;
        if (load_e0) begin
            e0_d.valid = 1'b1;
            e0_d.rd    = hz.id_rd;
            e0_d.wr    = hz.id_reg_write && (hz.id_rd != '0);
            e0_d.load  = hz.id_is_load;
            if (FWD_EN) begin
                if (m0_rs1)      sel_rs1_d = SEL_EXMEM;
                else if (m1_rs1) sel_rs1_d = SEL_MEMWB;
                if (m0_rs2)      sel_rs2_d = SEL_EXMEM;
                else if (m1_rs2) sel_rs2_d = SEL_MEMWB;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SB_DEPTH; i++) sb_q[i] <= '0;
            sel_rs1_q <= SEL_REG;
            sel_rs2_q <= SEL_REG;
        end else if (!hz.dmem_busy) begin
            sb_q[2]   <= sb_q[1];
            sb_q[1]   <= sb_q[0];
            sb_q[0]   <= e0_d;
            sel_rs1_q <= sel_rs1_d;
            sel_rs2_q <= sel_rs2_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (hz.perf_clear)
            stall_cnt_q <= '0;
        else if ((stall_raw || hz.dmem_busy) && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end

    assign hz.freeze       = !reset && hz.dmem_busy;
    assign hz.flush        = !reset && hz.branch_taken && !hz.dmem_busy;
    assign hz.bubble       = !reset && !hz.dmem_busy && (hz.branch_taken || hazard);
    assign hz.stall        = !reset && stall_raw;
    assign hz.fwd_sel_rs1  = sel_rs1_q;
    assign hz.fwd_sel_rs2  = sel_rs2_q;
    assign hz.stall_cycles = stall_cnt_q;
endmodule

// File: tb/tb_rv_hazard_ctrl.sv
// Bench for rv_hazard_ctrl: forwarding (p=0) and no-forwarding 3-bit-counter (p=1) instances
// driven in lockstep and checked every cycle against a rule-level model.
module tb_rv_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       branch_taken, dmem_busy, perf_clear;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) if_f ();
    rv_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(3))  if_n ();

    assign if_f.id_valid = id_valid;         assign if_n.id_valid = id_valid;
    assign if_f.id_rs1 = id_rs1;             assign if_n.id_rs1 = id_rs1;
    assign if_f.id_rs2 = id_rs2;             assign if_n.id_rs2 = id_rs2;
    assign if_f.id_rs1_used = id_rs1_used;   assign if_n.id_rs1_used = id_rs1_used;
    assign if_f.id_rs2_used = id_rs2_used;   assign if_n.id_rs2_used = id_rs2_used;
    assign if_f.id_rd = id_rd;               assign if_n.id_rd = id_rd;
    assign if_f.id_reg_write = id_reg_write; assign if_n.id_reg_write = id_reg_write;
    assign if_f.id_is_load = id_is_load;     assign if_n.id_is_load = id_is_load;
    assign if_f.branch_taken = branch_taken; assign if_n.branch_taken = branch_taken;
    assign if_f.dmem_busy = dmem_busy;       assign if_n.dmem_busy = dmem_busy;
    assign if_f.perf_clear = perf_clear;     assign if_n.perf_clear = perf_clear;

    rv_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b1), .CNT_W(32)) u_f (
        .clk(clk), .reset(reset), .hz(if_f.slave));
    rv_hazard_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b0), .CNT_W(3)) u_n (
        .clk(clk), .reset(reset), .hz(if_n.slave));

    // Model: per instance, in-flight writers by age (0 = EX, 1 = MEM, 2 = WB).
    typedef struct { bit v; int rd; bit wr; bit ld; } ent_t;
    ent_t   sbm [2][3];
    int     fs1 [2];
    int     fs2 [2];
    longint cnt [2];
    longint cmax [2] = '{64'hFFFF_FFFF, 7};

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit mm(int p, int k, int rs, bit used);
        return used && rs != 0 && sbm[p][k].v && sbm[p][k].wr && sbm[p][k].rd == rs;
    endfunction

    function automatic bit mhaz(int p);
        bit any0 = mm(p, 0, int'(id_rs1), id_rs1_used) || mm(p, 0, int'(id_rs2), id_rs2_used);
        bit any1 = mm(p, 1, int'(id_rs1), id_rs1_used) || mm(p, 1, int'(id_rs2), id_rs2_used);
        if (!id_valid) return 1'b0;
        if (p == 0) return any0 && sbm[0][0].ld;
        return any0 || any1;
    endfunction

    task automatic model_clear();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 3; k++) begin
                sbm[p][k].v = 0; sbm[p][k].rd = 0; sbm[p][k].wr = 0; sbm[p][k].ld = 0;
            end
            fs1[p] = 0; fs2[p] = 0; cnt[p] = 0;
        end
    endtask

    task automatic model_update();
        if (reset) begin
            model_clear();
            return;
        end
        for (int p = 0; p < 2; p++) begin
            bit h  = mhaz(p);
            bit st = !dmem_busy && h && !branch_taken;
            bit ld;
            int n1, n2;
            if (perf_clear) cnt[p] = 0;
            else if ((st || dmem_busy) && cnt[p] < cmax[p]) cnt[p]++;
            if (!dmem_busy) begin
                ld = id_valid && !h && !branch_taken;
                n1 = 0; n2 = 0;
                if (p == 0 && ld) begin
                    n1 = mm(p, 0, int'(id_rs1), id_rs1_used) ? 1 : mm(p, 1, int'(id_rs1), id_rs1_used) ? 2 : 0;
                    n2 = mm(p, 0, int'(id_rs2), id_rs2_used) ? 1 : mm(p, 1, int'(id_rs2), id_rs2_used) ? 2 : 0;
                end
                sbm[p][2] = sbm[p][1];
                sbm[p][1] = sbm[p][0];
                sbm[p][0].v  = ld;
                sbm[p][0].rd = ld ? int'(id_rd) : 0;
                sbm[p][0].wr = ld && id_reg_write && id_rd != 0;
                sbm[p][0].ld = ld && id_is_load;
                fs1[p] = n1;
                fs2[p] = n2;
            end
        end
    endtask

    task automatic chk_inst(input int p, input logic st, input logic bu, input logic fl,
                            input logic fr, input logic [1:0] s1, input logic [1:0] s2,
                            input longint c);
        bit h = mhaz(p);
        bit r = reset;
        check($sformatf("freeze[%0d]", p), fr, !r && dmem_busy);
        check($sformatf("flush[%0d]", p),  fl, !r && branch_taken && !dmem_busy);
        check($sformatf("bubble[%0d]", p), bu, !r && !dmem_busy && (branch_taken || h));
        check($sformatf("stall[%0d]", p),  st, !r && !dmem_busy && h && !branch_taken);
        check($sformatf("fwd_sel_rs1[%0d]", p), s1, fs1[p]);
        check($sformatf("fwd_sel_rs2[%0d]", p), s2, fs2[p]);
        check($sformatf("stall_cycles[%0d]", p), c, cnt[p]);
    endtask

    task automatic step();
        @(negedge clk);
        chk_inst(0, if_f.stall, if_f.bubble, if_f.flush, if_f.freeze,
                 if_f.fwd_sel_rs1, if_f.fwd_sel_rs2, longint'(if_f.stall_cycles));
        chk_inst(1, if_n.stall, if_n.bubble, if_n.flush, if_n.freeze,
                 if_n.fwd_sel_rs1, if_n.fwd_sel_rs2, longint'(if_n.stall_cycles));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_reg_write = 0; id_is_load = 0;
        branch_taken = 0; dmem_busy = 0; perf_clear = 0;
    endtask

    task automatic issue(input int rd, input bit wr, input bit ld,
                         input int r1, input bit u1, input int r2, input bit u2);
        set_idle();
        id_valid = 1; id_rd = 5'(rd); id_reg_write = wr; id_is_load = ld;
        id_rs1 = 5'(r1); id_rs1_used = u1; id_rs2 = 5'(r2); id_rs2_used = u2;
    endtask

    task automatic flush_pipe(input bit clr);
        set_idle();
        repeat (3) step();
        if (clr) begin
            perf_clear = 1;
            step();
            perf_clear = 0;
        end
    endtask

    initial begin
        set_idle();
        reset = 1;
        model_clear();
        repeat (2) step();
        check("reset_cnt", longint'(if_f.stall_cycles), 0);
        check("reset_sel", longint'(if_f.fwd_sel_rs1), 0);
        reset = 0;

        // ALU forwarding: EX then MEM producer
        flush_pipe(0);
        issue(5, 1, 0, 0, 0, 0, 0); step();
        issue(0, 0, 0, 5, 1, 0, 0); #1;
        check("alu_nostall", longint'(if_f.stall), 0);
        step();
        check("alu_sel_ex", longint'(if_f.fwd_sel_rs1), 1);
        issue(0, 0, 0, 5, 1, 0, 0); step();
        check("alu_sel_mem", longint'(if_f.fwd_sel_rs1), 2);

        // Load-use: one-cycle stall, then forward from MEM/WB
        flush_pipe(1);
        issue(7, 1, 1, 0, 0, 0, 0); step();
        issue(0, 0, 0, 0, 0, 7, 1); #1;
        check("lu_stall", longint'(if_f.stall), 1);
        check("lu_bubble", longint'(if_f.bubble), 1);
        step();
        check("lu_stall_gone", longint'(if_f.stall), 0);
        step();
        check("lu_sel", longint'(if_f.fwd_sel_rs2), 2);
        check("lu_cnt", longint'(if_f.stall_cycles), 1);

        // No forwarding: two stall cycles
        flush_pipe(1);
        issue(3, 1, 0, 0, 0, 0, 0); step();
        issue(0, 0, 0, 3, 1, 0, 0); #1;
        check("nf_stall1", longint'(if_n.stall), 1);
        step(); #1;
        check("nf_stall2", longint'(if_n.stall), 1);
        step(); #1;
        check("nf_go", longint'(if_n.stall), 0);
        step();
        check("nf_sel", longint'(if_n.fwd_sel_rs1), 0);
        check("nf_cnt", longint'(if_n.stall_cycles), 2);

        // x0 never tracked; youngest writer wins
        flush_pipe(0);
        issue(0, 1, 0, 0, 0, 0, 0); step();
        issue(0, 0, 0, 0, 1, 0, 1); #1;
        check("x0_nostall_f", longint'(if_f.stall), 0);
        check("x0_nostall_n", longint'(if_n.stall), 0);
        step();
        check("x0_sel", longint'(if_f.fwd_sel_rs1), 0);
        issue(4, 1, 0, 0, 0, 0, 0); step();
        issue(4, 1, 0, 0, 0, 0, 0); step();
        issue(0, 0, 0, 4, 1, 0, 0); step();
        check("x4_young", longint'(if_f.fwd_sel_rs1), 1);

        // Branch beats load-use; flushed instruction never enters EX
        flush_pipe(0);
        issue(9, 1, 1, 0, 0, 0, 0); step();
        issue(10, 1, 1, 9, 1, 0, 0); branch_taken = 1; #1;
        check("br_flush", longint'(if_f.flush), 1);
        check("br_bubble", longint'(if_f.bubble), 1);
        check("br_stall", longint'(if_f.stall), 0);
        step();
        issue(0, 0, 0, 10, 1, 0, 0); #1;
        check("br_e0_invalid", longint'(if_f.stall), 0);
        step();

        // Freeze holds state and counts
        flush_pipe(1);
        issue(6, 1, 0, 0, 0, 0, 0); step();
        issue(0, 0, 0, 6, 1, 0, 0); step();
        set_idle(); dmem_busy = 1; #1;
        check("fz_freeze", longint'(if_f.freeze), 1);
        check("fz_stall", longint'(if_f.stall), 0);
        repeat (3) step();
        check("fz_sel_held", longint'(if_f.fwd_sel_rs1), 1);
        check("fz_cnt", longint'(if_f.stall_cycles), 3);

        // Saturation (3-bit counter) and clear
        flush_pipe(1);
        dmem_busy = 1;
        repeat (9) step();
        check("sat_n", longint'(if_n.stall_cycles), 7);
        check("sat_f", longint'(if_f.stall_cycles), 9);
        dmem_busy = 0; perf_clear = 1; step(); perf_clear = 0;
        check("clr_n", longint'(if_n.stall_cycles), 0);
        check("clr_f", longint'(if_f.stall_cycles), 0);

        // Reset in the middle of a freeze
        issue(8, 1, 0, 0, 0, 0, 0); step();
        issue(0, 0, 0, 8, 1, 0, 0); step();
        set_idle(); dmem_busy = 1; step();
        #1; reset = 1; model_clear(); #1;
        check("rst_freeze", longint'(if_f.freeze), 0);
        check("rst_sel", longint'(if_f.fwd_sel_rs1), 0);
        check("rst_cnt", longint'(if_f.stall_cycles), 0);
        check("rst_freeze_n", longint'(if_n.freeze), 0);
        step();
        reset = 0; dmem_busy = 0;

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            id_valid     = ($urandom_range(0, 4) != 0);
            id_rs1       = 5'($urandom_range(0, 7));
            id_rs2       = 5'($urandom_range(0, 7));
            id_rd        = 5'($urandom_range(0, 7));
            id_rs1_used  = 1'($urandom_range(0, 1));
            id_rs2_used  = 1'($urandom_range(0, 1));
            id_reg_write = ($urandom_range(0, 3) != 0);
            id_is_load   = ($urandom_range(0, 2) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            dmem_busy    = ($urandom_range(0, 4) == 0);
            perf_clear   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) begin
                reset = 1;
                model_clear();
            end else begin
                reset = 0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
